// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler feeding one shared PISO with load/shift sequencing and frame strobes
module piso_tx_sched #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             piso_mode,
    output logic [WIDTH-1:0] piso_d,
    output logic             frame_valid,
    output logic             frame_last,
    output logic             frame_src,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;
    logic             last_q;
    logic             ack0_q, ack1_q, mode_q, fv_q, fl_q, src_q, busy_q;
    logic [WIDTH-1:0] pd_q;
    logic             win_d;

    // Winner: the lone requester, or the one not served last time on contention
    always_comb win_d = (req0 && req1) ? ~last_q : req1;

    // Frame sequencer: grant in IDLE, one load cycle, WIDTH shifts, then GAP idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            mode_q  <= 1'b1;
            pd_q    <= '0;
            fv_q    <= 1'b0;
            fl_q    <= 1'b0;
            src_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        ack0_q  <= ~win_d;
                        ack1_q  <= win_d;
                        pd_q    <= win_d ? data1 : data0;
                        src_q   <= win_d;
                        last_q  <= win_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    mode_q  <= 1'b0;
                    fv_q    <= 1'b1;
                    fl_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        fv_q   <= 1'b0;
                        fl_q   <= 1'b0;
                        mode_q <= 1'b1;
                        gap_q  <= '0;
                        if (GAP == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        fl_q  <= (cnt_q == CW'(WIDTH - 2));
                    end
                end
                S_GAP: begin
                    if (int'(gap_q) >= GAP - 1) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign piso_mode   = mode_q;
    assign piso_d      = pd_q;
    assign frame_valid = fv_q;
    assign frame_last  = fl_q;
    assign frame_src   = src_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_piso_tx_sched.sv
// tb_piso_tx_sched: vector table, directed corner sequences and random stimulus against a frame-timer model
module tb_piso_tx_sched;
    localparam int W = 4;

    logic         clk, rst_n, req0, req1;
    logic [W-1:0] data0, data1;
    logic         a0[2], a1[2], md[2], fv[2], fl[2], sr[2], bz[2];
    logic [W-1:0] pd[2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference: per instance, a timer t counting cycles since grant (t=0 is the ack cycle)
    bit           m_act[2];
    int           m_t[2];
    bit           m_last[2], m_src[2];
    logic [W-1:0] m_pd[2];
    int           m_gap[2] = '{1, 0};

    piso_tx_sched #(.WIDTH(W), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(a0[0]), .ack1(a1[0]), .piso_mode(md[0]), .piso_d(pd[0]), .frame_valid(fv[0]),
        .frame_last(fl[0]), .frame_src(sr[0]), .busy(bz[0]));

    piso_tx_sched #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(a0[1]), .ack1(a1[1]), .piso_mode(md[1]), .piso_d(pd[1]), .frame_valid(fv[1]),
        .frame_last(fl[1]), .frame_src(sr[1]), .busy(bz[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_t[k] = 0; m_last[k] = 1; m_src[k] = 0; m_pd[k] = '0;
        end
    endtask

    task automatic medge();
        bit w;
        if (!rst_n) begin
            mreset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!m_act[k]) begin
                if (req0 || req1) begin
                    w = (req0 && req1) ? !m_last[k] : req1;
                    m_act[k] = 1; m_t[k] = 0; m_last[k] = w; m_src[k] = w;
                    m_pd[k] = w ? data1 : data0;
                end
            end else begin
                m_t[k]++;
                if (m_t[k] == W + m_gap[k] + 1) m_act[k] = 0;
            end
        end
    endtask

    task automatic mcheck();
        bit sh;
        for (int k = 0; k < 2; k++) begin
            sh = m_act[k] && m_t[k] >= 1 && m_t[k] <= W;
            chk("ack0", k, 32'(a0[k]), 32'(m_act[k] && m_t[k] == 0 && !m_src[k]));
            chk("ack1", k, 32'(a1[k]), 32'(m_act[k] && m_t[k] == 0 && m_src[k]));
            chk("mode", k, 32'(md[k]), 32'(!sh));
            chk("valid", k, 32'(fv[k]), 32'(sh));
            chk("last", k, 32'(fl[k]), 32'(m_act[k] && m_t[k] == W));
            chk("busy", k, 32'(bz[k]), 32'(m_act[k]));
            chk("src", k, 32'(sr[k]), 32'(m_src[k]));
            chk("piso_d", k, 32'(pd[k]), 32'(m_pd[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        medge();
        @(negedge clk);
        mcheck();
    endtask

    task automatic do_reset();
        rst_n = 0; req0 = 0; req1 = 0;
        step();
        step();
        rst_n = 1;
    endtask

    typedef struct {
        bit r0, r1;
        bit a0, a1, m;
        logic [W-1:0] pd;
        bit fv, fl, src, busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int rel, mcnt, bcnt;
        int na[2];
        int at[2][3];
        int gq[$];
        int exp_g[4] = '{0, 1, 0, 1};

        //            r0 r1 a0 a1 m  pd      fv fl src busy
        tbl[0] = '{1, 0, 1, 0, 1, 4'b1010, 0, 0, 0, 1};
        tbl[1] = '{0, 0, 0, 0, 0, 4'b1010, 1, 0, 0, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 4'b1010, 1, 0, 0, 1};
        tbl[3] = '{0, 0, 0, 0, 0, 4'b1010, 1, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 4'b1010, 1, 1, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 1, 4'b1010, 0, 0, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 1, 4'b1010, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 0, 1, 1, 4'b0110, 0, 0, 1, 1};

        data0 = 4'b1010; data1 = 4'b0110;
        mreset();
        do_reset();

        // Reset state on the GAP=1 instance
        chk("rst_mode", 0, 32'(md[0]), 1);
        chk("rst_busy", 0, 32'(bz[0]), 0);
        chk("rst_pd", 0, 32'(pd[0]), 0);

        // Single frame from requester 0, then a lone request from 1
        for (int i = 0; i < 8; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            step();
            chk($sformatf("tbl%0d_ack0", i), 0, 32'(a0[0]), 32'(tbl[i].a0));
            chk($sformatf("tbl%0d_ack1", i), 0, 32'(a1[0]), 32'(tbl[i].a1));
            chk($sformatf("tbl%0d_mode", i), 0, 32'(md[0]), 32'(tbl[i].m));
            chk($sformatf("tbl%0d_pd", i), 0, 32'(pd[0]), 32'(tbl[i].pd));
            chk($sformatf("tbl%0d_valid", i), 0, 32'(fv[0]), 32'(tbl[i].fv));
            chk($sformatf("tbl%0d_last", i), 0, 32'(fl[0]), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_src", i), 0, 32'(sr[0]), 32'(tbl[i].src));
            chk($sformatf("tbl%0d_busy", i), 0, 32'(bz[0]), 32'(tbl[i].busy));
        end
        req1 = 0;
        for (int i = 0; i < 8; i++) step();

        // Contention: grants alternate 0,1,0,1
        do_reset();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 40 && gq.size() < 4; i++) begin
            step();
            if (a0[0]) begin
                gq.push_back(0);
                chk("cont_pd0", 0, 32'(pd[0]), 32'(4'b1010));
            end
            if (a1[0]) begin
                gq.push_back(1);
                chk("cont_pd1", 0, 32'(pd[0]), 32'(4'b0110));
            end
            req0 = !a0[0]; req1 = !a1[0];
        end
        chk("cont_count", 0, gq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), 0, (i < gq.size()) ? gq[i] : -1, exp_g[i]);

        // Back-to-back single requester on both GAP settings
        do_reset();
        req1 = 1;
        na = '{0, 0}; mcnt = 0; bcnt = 0;
        for (int k = 0; k < 2; k++) for (int j = 0; j < 3; j++) at[k][j] = -100 * (j + 1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (na[0] == 1 && md[0]) mcnt++;
            if (na[1] == 1 && !bz[1]) bcnt++;
            for (int k = 0; k < 2; k++) if (a1[k] && na[k] < 3) begin at[k][na[k]] = cyc; na[k]++; end
        end
        req1 = 0;
        chk("b2b_period_a", 0, at[0][1] - at[0][0], 7);
        chk("b2b_period_b", 0, at[0][2] - at[0][1], 7);
        chk("b2b_period_a", 1, at[1][1] - at[1][0], 6);
        chk("b2b_period_b", 1, at[1][2] - at[1][1], 6);
        chk("b2b_mode_hi", 0, mcnt, 3);
        chk("b2b_busy_lo", 1, bcnt, 1);

        // Late request: req1 raised during a req0 frame waits for the next IDLE edge
        do_reset();
        req0 = 1;
        step();
        req0 = 0;
        step();
        step();
        req1 = 1;
        rel = 2;
        for (int i = 0; i < 20; i++) begin
            step();
            rel++;
            if (a1[0]) break;
        end
        req1 = 0;
        chk("late_ack_rel", 0, rel, 7);
        for (int i = 0; i < 8; i++) step();

        // Reset in the second shift cycle, then contention favours requester 0
        do_reset();
        req0 = 1;
        step();
        req0 = 0;
        step();
        step();
        #1 rst_n = 0;
        #1;
        chk("mid_rst_valid", 0, 32'(fv[0]), 0);
        chk("mid_rst_mode", 0, 32'(md[0]), 1);
        chk("mid_rst_busy", 0, 32'(bz[0]), 0);
        chk("mid_rst_pd", 0, 32'(pd[0]), 0);
        chk("mid_rst_last", 0, 32'(fl[0]), 0);
        mreset();
        req0 = 1; req1 = 1;
        #1 rst_n = 1;
        step();
        chk("post_rst_ack0", 0, 32'(a0[0]), 1);
        chk("post_rst_ack1", 0, 32'(a1[0]), 0);
        req0 = 0; req1 = 0;
        for (int i = 0; i < 8; i++) step();

        // Random requests, data and occasional resets against the model
        for (int i = 0; i < 2000; i++) begin
            req0  = $urandom_range(0, 2) != 0;
            req1  = $urandom_range(0, 2) != 0;
            data0 = W'($urandom);
            data1 = W'($urandom);
            rst_n = $urandom_range(0, 199) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_tx_sched.md
# piso_tx_sched

Round-robin scheduler that shares one PISO shift register between two parallel-word requesters. It grants one requester per frame, drives the PISO's parallel data and `mode` inputs, and sequences one load cycle followed by WIDTH shift cycles. It also emits frame-qualifying strobes that mark when the PISO serial output carries valid bits. It sits directly in front of the PISO (`mode`=1 loads `d`, `mode`=0 shifts one bit per `clk`).

## Interface
- `WIDTH`, default 4: PISO word width; number of shift cycles per frame (≥2).
- `GAP`, default 1: idle cycles inserted after each frame before the next grant (≥0).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  request from requester 0 / 1. Held high with data stable until the matching ack is seen.
- `data0` / `data1`  in  WIDTH  word to serialise for requester 0 / 1.
- `ack0` / `ack1`  out  1  one-cycle grant pulse. Data was captured.
- `piso_mode`  out  1  PISO `mode`: 1 = load, 0 = shift.
- `piso_d`  out  WIDTH  PISO parallel input.
- `frame_valid`  out  1  high in exactly the WIDTH cycles the PISO serial output carries frame bits.
- `frame_last`  out  1  high in the final `frame_valid` cycle.
- `frame_src`  out  1  index of the requester that owns the current/last frame.
- `busy`  out  1  high from LOAD through GAP.

## Operation
- All outputs are registered. Reset values: `ack0`=`ack1`=0, `piso_mode`=1, `piso_d`=0, `frame_valid`=0, `frame_last`=0, `frame_src`=0, `busy`=0, state=IDLE, bit counter=0, rr pointer `last`=1.
- **FSM states:** IDLE, LOAD, SHIFT, GAP.
- **IDLE**
  - `piso_mode`=1, so the PISO continuously reloads; `so` is don't-care.
  - On an edge with any req high, pick a winner and load `piso_d` from the winner's data.
  - Pulse the winner's ack for the next cycle, set `frame_src`=winner, set `busy`=1, go to LOAD.
  - With no req, stay in IDLE.
- **Arbitration**
  - A single request is always granted.
  - If both are high, grant the index ≠ `last`.
  - `last` updates to the winner at grant.
  - Because `last` resets to 1, requester 0 wins the first contention.
- **LOAD** (1 cycle)
  - `piso_mode`=1 and `piso_d` is stable; the PISO captures the word on the closing edge.
  - On that edge: ack←0, `piso_mode`←0, `frame_valid`←1, counter←0, go to SHIFT.
- **SHIFT** (WIDTH cycles)
  - `piso_mode`=0. The counter increments each edge.
  - `frame_last` is registered so it is high only when counter = WIDTH-1.
  - On the edge leaving count WIDTH-1: `frame_valid`←0, `frame_last`←0, `piso_mode`←1.
  - Then go to GAP, or to IDLE with `busy`←0 if GAP=0.
- **GAP** (GAP cycles)
  - `piso_mode`=1 and requests are not sampled.
  - After GAP cycles, go to IDLE with `busy`←0.
- Requests are sampled only in IDLE. A req held high through LOAD/SHIFT/GAP is ignored until the next IDLE.
- A req dropped before grant is never acked, and no state changes.
- Counter width is clog2(WIDTH). The counter never exceeds WIDTH-1 and clears at LOAD.
- **Reset mid-frame:** all state and outputs return to reset values asynchronously. The frame is aborted with no further strobes. The aborted requester's ack is not reissued; it must re-request.

## Timing
- req high before edge E0 (state IDLE) → ack high in cycle E0..E1 (LOAD).
- `frame_valid` is high for cycles E1..E(WIDTH+1); `frame_last` is high in cycle E(WIDTH)..E(WIDTH+1).
- Grant latency: 1 cycle to ack, 2 cycles to the first valid bit.
- Frame period with continuous requests is WIDTH+GAP+2 cycles: 1 LOAD + WIDTH SHIFT + GAP + 1 IDLE. With the defaults this is 7.
- `busy` rises with ack and falls on entry to IDLE.
- No combinational path from any input to any output.

## Test plan
- **Single frame:** req0=1, `data0`=4'b1010 → `ack0` high 1 cycle, `piso_d`=1010 with `piso_mode`=1 in that cycle, then `piso_mode`=0 and `frame_valid`=1 for exactly 4 cycles, `frame_last` on the 4th, `frame_src`=0, `ack1` never asserted.
- **Contention:** req0 and req1 high together, `data0`=1010, `data1`=0110, each requester re-raising req right after its ack → grants 0,1,0,1 across 4 frames. `piso_d` alternates 1010/0110 and `frame_src` alternates 0/1.
- **Back-to-back single requester:** req1 held and re-raised after each ack → acks exactly 7 cycles apart. `piso_mode` is 1 for 3 cycles between shift bursts (GAP+IDLE+LOAD).
- **GAP=0:** same stimulus → acks 6 cycles apart, `busy` low for exactly 1 cycle between frames.
- **Reset mid-SHIFT:** `rst_n`→0 at the 2nd shift cycle → immediately `frame_valid`=0, `piso_mode`=1, `busy`=0, `piso_d`=0. After release with req0=req1=1, requester 0 is granted first.
- **Late request:** req1 raised during SHIFT of a req0 frame → not acked until the next IDLE edge; no ack during LOAD/SHIFT/GAP.
